pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side program counter sequencer for the 16-bit pipeline. It consumes the taken/not-taken decision from `branch_comp` in the execute stage, so it is the receiving end of the branch decision path. It issues one instruction address per cycle and computes PC-relative branch targets. On a taken branch or jump it redirects fetch and pulses a one-cycle flush to squash wrong-path instructions. It also maintains saturating branch statistics counters.

## Interface
- `ADDR_WIDTH`, 16: PC and target width.
- `OFFSET_WIDTH`, 8: signed branch offset width, sign-extended to `ADDR_WIDTH`.
- `RESET_VECTOR`, 16'h0000: first fetch address after reset.
- `COUNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hold the PC; no increment this cycle.
- `halt`  in  1: enter HALTED; only reset exits.
- `branch_valid`  in  1: a conditional branch occupies EX this cycle.
- `branch`  in  1: taken decision from `branch_comp`; ignored unless `branch_valid` is high.
- `branch_pc`  in  ADDR_WIDTH: address of the branch in EX.
- `branch_offset`  in  OFFSET_WIDTH: signed word offset.
- `jump`  in  1: unconditional jump in EX.
- `jump_target`  in  ADDR_WIDTH: absolute jump address.
- `pc`  out  ADDR_WIDTH: current fetch address.
- `pc_valid`  out  1: `pc` is a live fetch request.
- `flush`  out  1: squash IF/ID contents this cycle.
- `branch_count`  out  COUNT_WIDTH: number of resolved conditional branches (saturating).
- `taken_count`  out  COUNT_WIDTH: number of taken conditional branches (saturating).

## Operation
- States:
  - **BOOT**: entered on reset.
  - **RUN**.
  - **HALTED**.
- Transitions:
  - BOOT→RUN unconditionally after one cycle.
  - RUN→HALTED when `halt`=1.
  - HALTED is absorbing until reset.
- **Redirect condition** (RUN only): `redirect` = (`branch_valid` & `branch`) | `jump`.
- **Branch target**: `branch_pc` + 1 + sign_extend(`branch_offset`), computed modulo 2^ADDR_WIDTH.
- **Redirect priority**: a taken branch outranks `jump` when both are asserted. That combination is illegal upstream, but the behaviour is defined.
- **Next-PC priority in RUN**: `halt` > redirect > `stall` > increment.
  - A redirect proceeds despite `stall`.
  - `halt` in the same cycle as a redirect: the PC is not updated, `flush` is not raised, and the state becomes HALTED.
- **Increment**: `pc` + 1, wrapping 0xFFFF→0x0000 with no flag.
- **Counters**:
  - Each cycle in RUN with `branch_valid`=1 increments `branch_count`.
  - Such a cycle with `branch`=1 also increments `taken_count`.
  - Both counters saturate at all-ones.
  - Counters also update in a cycle where `halt` wins. They do not update in BOOT or HALTED.
- **Inputs in BOOT/HALTED**: all inputs except `reset_n` are ignored.

## Timing
- **Reset values** (applied asynchronously, immediately on `reset_n` low):
  - `pc`=RESET_VECTOR, `pc_valid`=0, `flush`=0.
  - `branch_count`=0, `taken_count`=0, state=BOOT.
- **After reset release**:
  - Cycle 0: `pc_valid`=0.
  - Cycle 1 onward: `pc_valid`=1 with `pc`=RESET_VECTOR.
- **Redirect latency**: a redirect sampled at edge N produces, in cycle N+1:
  - `pc` = target and `pc_valid`=1.
  - `flush`=1 for exactly that cycle.
- **Back-to-back redirects**: each produces its own one-cycle `flush`, so `flush` may stay high across consecutive cycles.
- **Stall**: `pc` and `pc_valid` are unchanged while `stall`=1 and no redirect occurs.
- **Halt**: sampled at edge N gives `pc_valid`=0 from cycle N+1. `pc` then holds its last value.
- **Registered outputs**: all outputs come directly from flops; there is no combinational input-to-output path.

## Structure
- **Shared include `branch_defs.vh`**, containing:
  - The existing BRANCH_GT/LT/EQ codes and REG_DATA_WIDTH.
  - New state encodings PCS_BOOT=2'b00, PCS_RUN=2'b01, PCS_HALTED=2'b10.
  - The default ADDR_WIDTH.
- **Sub-module `branch_target_adder`**: combinational; sign-extends `branch_offset` and adds it to `branch_pc`+1. Instantiated once.
- **Main module contents**: the state register, next-PC mux, flush flop and the two saturating counters.

## Test plan
- **Reset/boot**: release reset. Required: cycle 0 `pc_valid`=0; cycle 1 `pc`=0x0000 with `pc_valid`=1; cycle 4 `pc`=0x0003.
- **Taken branch**: `branch_pc`=0x0010, `branch_offset`=-4 (8'hFC), `branch_valid`=`branch`=1 for one cycle. Required next cycle: `pc`=0x000D, `flush`=1; following cycle `flush`=0; `taken_count`=1, `branch_count`=1.
- **Not-taken branch**: `branch_valid`=1, `branch`=0. Required: sequential `pc`, `flush` never high, `branch_count`+1, `taken_count` unchanged.
- **Stall vs redirect**: `stall`=1 held 3 cycles → `pc` frozen. Then `jump`=1 to 0x1234 while `stall`=1 → next cycle `pc`=0x1234, `flush`=1.
- **Wrap and saturation**:
  - `jump_target`=0xFFFF → next cycle `pc`=0xFFFF, the cycle after `pc`=0x0000.
  - With COUNT_WIDTH=4, 20 taken branches → `taken_count`=4'hF.
- **Halt and async reset**:
  - `halt`=1 together with a taken branch → `pc_valid`=0 next cycle, `pc` not updated, `flush`=0.
  - Assert `reset_n`=0 mid-cycle → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared branch codes, sequencer state encodings and default widths.
package pc_sequencer_pkg;
    localparam logic [1:0] BRANCH_EQ = 2'b00;
    localparam logic [1:0] BRANCH_LT = 2'b01;
    localparam logic [1:0] BRANCH_GT = 2'b10;
    localparam int REG_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        PCS_BOOT   = 2'b00,
        PCS_RUN    = 2'b01,
        PCS_HALTED = 2'b10
    } pcs_e;
endpackage

// File: rtl/pc_sequencer_branch_target_adder.sv
// branch_target_adder: PC-relative target = pc + 1 + sign-extended offset, modulo 2^ADDR_WIDTH.
module branch_target_adder #(
    parameter int ADDR_WIDTH   = 16,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0]   pc_i,
    input  logic [OFFSET_WIDTH-1:0] offset_i,
    output logic [ADDR_WIDTH-1:0]   target_o
);
    assign target_o = pc_i + ADDR_WIDTH'(1) + ADDR_WIDTH'($signed(offset_i));
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencer with branch/jump redirect, one-cycle flush and
// saturating branch statistics; every output is a flop.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int                    OFFSET_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic                    halt,
    input  logic                    branch_valid,
    input  logic                    branch,
    input  logic [ADDR_WIDTH-1:0]   branch_pc,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    jump,
    input  logic [ADDR_WIDTH-1:0]   jump_target,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    pc_valid,
    output logic                    flush,
    output logic [COUNT_WIDTH-1:0]  branch_count,
    output logic [COUNT_WIDTH-1:0]  taken_count
);
    pcs_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d, branch_target;
    logic                   pc_valid_q, pc_valid_d, flush_q, flush_d;
    logic [COUNT_WIDTH-1:0] branch_count_q, branch_count_d, taken_count_q, taken_count_d;
    logic                   run, taken, redirect, advance;

    branch_target_adder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_target (
        .pc_i    (branch_pc),
        .offset_i(branch_offset),
        .target_o(branch_target)
    );

    always_comb begin
        run            = state_q == PCS_RUN;
        taken          = branch_valid && branch;
        redirect       = taken || jump;
        advance        = run && !halt;
        state_d        = (state_q == PCS_BOOT) ? PCS_RUN : (run && halt) ? PCS_HALTED : state_q;
        pc_valid_d     = state_d == PCS_RUN;
        // A taken branch outranks a simultaneous jump; a redirect overrides stall.
        pc_d           = !advance ? pc_q : taken ? branch_target : jump ? jump_target :
                         stall ? pc_q : pc_q + ADDR_WIDTH'(1);
        flush_d        = advance && redirect;
        branch_count_d = (run && branch_valid && !(&branch_count_q)) ?
                         branch_count_q + COUNT_WIDTH'(1) : branch_count_q;
        taken_count_d  = (run && taken && !(&taken_count_q)) ?
                         taken_count_q + COUNT_WIDTH'(1) : taken_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= PCS_BOOT;
            pc_q           <= RESET_VECTOR;
            pc_valid_q     <= 1'b0;
            flush_q        <= 1'b0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pc_valid_q     <= pc_valid_d;
            flush_q        <= flush_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign flush        = flush_q;
    assign branch_count = branch_count_q;
    assign taken_count  = taken_count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, hand-written corner sequences and a randomized
// run against a behavioural model of the fetch sequencer (COUNT_WIDTH=4 to reach saturation).
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 0, halt = 0, branch_valid = 0, branch = 0, jump = 0;
    logic [15:0] branch_pc = '0, jump_target = '0;
    logic [7:0]  branch_offset = '0;
    logic [15:0] pc;
    logic        pc_valid, flush;
    logic [3:0]  branch_count, taken_count;
    int          passed = 0, total = 0;

    typedef struct {
        logic        st, hl, bv, br;
        logic [15:0] bpc;
        logic [7:0]  boff;
        logic        jp;
        logic [15:0] jt;
        logic [15:0] epc;
        logic        ev, ef;
        logic [3:0]  ebc, etc;
    } vec_t;

    vec_t tbl[16];

    // behavioural model state
    bit started, halted_m, m_valid, m_flush;
    int m_pc, m_bc, m_tc;

    pc_sequencer #(.COUNT_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .halt(halt),
        .branch_valid(branch_valid), .branch(branch), .branch_pc(branch_pc),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, hl, bv, br, input logic [15:0] bpc,
                         input logic [7:0] boff, input logic jp, input logic [15:0] jt);
        stall = st; halt = hl; branch_valid = bv; branch = br;
        branch_pc = bpc; branch_offset = boff; jump = jp; jump_target = jt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 16'h0, 8'h0, 0, 16'h0);
    endtask

    task automatic check_all(input string tag, input logic [15:0] epc, input logic ev, ef,
                             input logic [3:0] ebc, etc);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".pc_valid"}, {15'b0, pc_valid}, {15'b0, ev});
        chk({tag, ".flush"}, {15'b0, flush}, {15'b0, ef});
        chk({tag, ".branch_count"}, {12'b0, branch_count}, {12'b0, ebc});
        chk({tag, ".taken_count"}, {12'b0, taken_count}, {12'b0, etc});
    endtask

    // Model: one rising edge with the currently driven inputs.
    task automatic model_edge();
        int so;
        so = int'($signed(branch_offset));
        if (!started) begin
            started = 1; m_valid = 1; m_flush = 0;
        end else if (halted_m) begin
            m_flush = 0;
        end else begin
            if (branch_valid) m_bc = (m_bc == 15) ? 15 : m_bc + 1;
            if (branch_valid && branch) m_tc = (m_tc == 15) ? 15 : m_tc + 1;
            if (halt) begin
                halted_m = 1; m_valid = 0; m_flush = 0;
            end else if (branch_valid && branch) begin
                m_pc = (int'(branch_pc) + 1 + so) & 16'hFFFF; m_flush = 1;
            end else if (jump) begin
                m_pc = int'(jump_target); m_flush = 1;
            end else begin
                m_flush = 0;
                if (!stall) m_pc = (m_pc + 1) & 16'hFFFF;
            end
        end
    endtask

    task automatic model_reset();
        started = 0; halted_m = 0; m_valid = 0; m_flush = 0;
        m_pc = 0; m_bc = 0; m_tc = 0;
    endtask

    task automatic do_reset();
        #3 reset_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] held_pc;
        //         st hl bv br bpc       boff   jp jt        epc       ev ef bc tc
        tbl[0]  = '{0, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h0000, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h0001, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h0002, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h0003, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 16'h0010, 8'hFC, 0, 16'h0000, 16'h000D, 1, 1, 1, 1};
        tbl[5]  = '{0, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h000E, 1, 0, 1, 1};
        tbl[6]  = '{0, 0, 1, 0, 16'h0040, 8'h10, 0, 16'h0000, 16'h000F, 1, 0, 2, 1};
        tbl[7]  = '{1, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h000F, 1, 0, 2, 1};
        tbl[8]  = '{1, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h000F, 1, 0, 2, 1};
        tbl[9]  = '{1, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h000F, 1, 0, 2, 1};
        tbl[10] = '{1, 0, 0, 0, 16'h0000, 8'h00, 1, 16'h1234, 16'h1234, 1, 1, 2, 1};
        tbl[11] = '{0, 0, 0, 0, 16'h0000, 8'h00, 1, 16'hFFFF, 16'hFFFF, 1, 1, 2, 1};
        tbl[12] = '{0, 0, 0, 0, 16'h0000, 8'h00, 0, 16'h0000, 16'h0000, 1, 0, 2, 1};
        tbl[13] = '{0, 0, 1, 1, 16'h0100, 8'h05, 1, 16'h2000, 16'h0106, 1, 1, 3, 2};
        tbl[14] = '{0, 0, 1, 1, 16'hFFFF, 8'h01, 0, 16'h0000, 16'h0001, 1, 1, 4, 3};
        tbl[15] = '{0, 0, 0, 1, 16'h0300, 8'h07, 0, 16'h0000, 16'h0002, 1, 0, 4, 3};

        #2 check_all("reset", 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("boot_cycle0.pc_valid", {15'b0, pc_valid}, 16'h0);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].st, tbl[i].hl, tbl[i].bv, tbl[i].br, tbl[i].bpc, tbl[i].boff,
                  tbl[i].jp, tbl[i].jt);
            step();
            check_all($sformatf("tbl[%0d]", i), tbl[i].epc, tbl[i].ev, tbl[i].ef,
                      tbl[i].ebc, tbl[i].etc);
        end

        // 20 taken branches saturate both 4-bit counters
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 1, 16'h0100, 8'h00, 0, 16'h0);
            step();
        end
        idle();
        step();
        check_all("saturate", 16'h0102, 1, 0, 4'hF, 4'hF);

        // halt together with a taken branch: no redirect, no flush
        held_pc = pc;
        drive(0, 1, 1, 1, 16'h0500, 8'h20, 0, 16'h0);
        step();
        check_all("halt_vs_branch", held_pc, 0, 0, 4'hF, 4'hF);
        drive(0, 0, 1, 1, 16'h0600, 8'h01, 1, 16'h7777);
        repeat (3) step();
        check_all("halted_ignores", held_pc, 0, 0, 4'hF, 4'hF);

        // asynchronous reset mid-cycle
        #3 reset_n = 1'b0;
        #1 check_all("async_reset", 16'h0000, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;

        // randomized run against the model, halting occasionally and resetting periodically
        model_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 160 == 159) do_reset();
            drive($urandom % 4 == 0, $urandom % 64 == 0, $urandom % 3 == 0, $urandom % 2 == 1,
                  16'($urandom), 8'($urandom), $urandom % 8 == 0, 16'($urandom));
            model_edge();
            step();
            check_all($sformatf("rand[%0d]", i), 16'(m_pc), m_valid, m_flush, 4'(m_bc), 4'(m_tc));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
